// File: rtl/or_rr_arbiter.sv
// rtl/or_rr_arbiter.sv - round-robin shared registered OR datapath with single response channel
module or_rr_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 1,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_q,
  output logic [IDW-1:0] rsp_id
);

  // ptr holds the last granted index; requester ptr+1 has highest priority
  logic [IDW-1:0] ptr;
  // run stays low until the first edge after reset release, keeping req_ready quiet meanwhile
  logic           run;
  logic           accept;
  logic [N-1:0]   grant;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] cand;
  logic           found;
  logic           xfer;

  // output register can take a new result when empty or being drained this cycle
  assign accept = !rsp_valid || rsp_ready;

  // rotating scan from ptr+1 modulo N; first valid requester wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    if (run && accept) begin
      for (int k = 1; k <= N; k++) begin
        cand = IDW'((int'(ptr) + k) % N);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gidx        = cand;
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = found;

  // output register, pointer update and reset-release tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      ptr       <= IDW'(N - 1);
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_id    <= '0;
    end else begin
      run <= 1'b1;
      if (xfer) begin
        rsp_q     <= req_a[int'(gidx)*W +: W] | req_b[int'(gidx)*W +: W];
        rsp_id    <= gidx;
        rsp_valid <= 1'b1;
        ptr       <= gidx;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/or_rr_arbiter.md
Name: or_rr_arbiter

Overview:
- Shares one registered two-operand OR datapath (Q = A | B) between N requesters.
- Each requester presents operands under a valid/ready handshake.
- A round-robin arbiter grants at most one requester per cycle.
- The result is returned with the winner's index on a single response channel with backpressure.
- Sits between requester blocks and the downstream consumer of the OR result.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- W, 1, operand and result width in bits; legal range 1..32.
- IDW, max(1,$clog2(N)), width of the requester index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clk.
- req_valid  input  N  per-requester request valid.
- req_ready  output  N  per-requester accept, one-hot or zero.
- req_a  input  N*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  N*W  operand B; same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accept.
- rsp_q  output  W  registered A | B of the granted requester.
- rsp_id  output  IDW  index of the requester that produced rsp_q.

Behaviour:
- Reset values (rst low, asynchronous):
  - rsp_valid=0, rsp_q=0, rsp_id=0.
  - Priority pointer ptr=N-1, so requester 0 has highest priority after reset.
  - req_ready is all zero while rst is low.
- Internal state: ptr (IDW bits) holds the last granted index, plus a single-entry output register (rsp_valid/rsp_q/rsp_id).
- accept = !rsp_valid || rsp_ready. This is combinational: the output register can be loaded this cycle.
- Grant (combinational): scan indices ptr+1, ptr+2, … modulo N. The first i with req_valid[i]=1 wins.
  - If accept=0 or no req_valid is set, grant is zero.
- req_ready[i] = grant[i]. At most one bit is set per cycle.
  - req_ready depends on req_valid and rsp_ready only, with no other combinational inputs.
- Transfer on requester i = req_valid[i] && req_ready[i]. At the next edge:
  - rsp_q <= req_a[i] | req_b[i] (bitwise, W bits).
  - rsp_id <= i.
  - rsp_valid <= 1.
  - ptr <= i.
- Response handshake:
  - If rsp_valid && rsp_ready and no transfer occurs this cycle, rsp_valid <= 0.
  - rsp_q and rsp_id hold their last values.
- Simultaneous response drain and new transfer in the same cycle: the register reloads and rsp_valid stays 1. This gives full throughput of one result per cycle.
- Stall: if rsp_valid=1 and rsp_ready=0, then req_ready is all zero and rsp_valid/rsp_q/rsp_id remain stable.
- Latency: one cycle from the transfer edge to rsp_valid.
- ptr update: ptr only changes on a transfer. Idle cycles keep the rotation position.
- Wrap-around: after granting N-1, the next scan starts at 0.
- Fairness: with all N requesters continuously valid and rsp_ready=1, grants are 0,1,…,N-1,0,… and no requester waits more than N-1 grants.
- Requester rule: once req_valid is asserted, the requester holds it and its operands until req_ready. The arbiter does not check this.
- Reset mid-operation:
  - Any pending response is discarded (rsp_valid forced to 0) and ptr returns to N-1.
  - No req_ready is issued until the first edge after rst deasserts.
- Non-power-of-two N: the scan is modulo N, and indices ≥N are never produced.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 → req_ready=0000, rsp_valid=0, rsp_q=0. Release rst with rsp_ready=1 → first grant is requester 0, and the next cycle shows rsp_valid=1, rsp_id=0.
- Single request, W=4: only requester 2 valid, a=4'b1010, b=4'b0101, rsp_ready=1 → req_ready=0100 for one cycle; next cycle rsp_q=4'b1111, rsp_id=2, rsp_valid=1; the following cycle rsp_valid=0.
- Round-robin fairness: N=4, all req_valid=1 for 8 cycles, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,2,3 with rsp_valid=1 on every cycle after the first.
- Backpressure: response pending with rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid → req_ready=0000 and rsp_q/rsp_id stable for those 3 cycles; on rsp_ready=1, requester 1 or 3 is granted per ptr order, and no result is lost or duplicated.
- Wrap and skip: ptr=2 (last grant 2), only requesters 0 and 1 valid → grant 0 first, then 1; requester 3 is not granted.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 → rsp_valid drops immediately without waiting for clk; after release, the grant order restarts at requester 0.
